// File: rtl/mult_bus_sequencer_pkg.sv
// Shared types for mult_bus_sequencer: FSM states,
// peripheral register map and bus strobe helpers.
package mult_bus_sequencer_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ARB,
    S_WR_A,
    S_WR_B,
    S_INIT_SET,
    S_INIT_CLR,
    S_POLL_RD,
    S_POLL_CHK,
    S_POLL_WAIT,
    S_RES_RD,
    S_RES_CAP,
    S_RESP,
    S_ABORT
  } state_t;

  localparam logic [4:0] ADDR_A      = 5'h01;
  localparam logic [4:0] ADDR_B      = 5'h02;
  localparam logic [4:0] ADDR_INIT   = 5'h04;
  localparam logic [4:0] ADDR_RESULT = 5'h08;
  localparam logic [4:0] ADDR_DONE   = 5'h10;

  typedef struct packed {
    logic        cs;
    logic        rd;
    logic        wr;
    logic [4:0]  addr;
    logic [15:0] data;
  } bus_t;

  function automatic bus_t bus_wr(
    input logic [4:0]  a,
    input logic [15:0] d
  );
    return '{cs: 1'b1, rd: 1'b0, wr: 1'b1,
             addr: a, data: d};
  endfunction

  function automatic bus_t bus_rd(
    input logic [4:0] a
  );
    return '{cs: 1'b1, rd: 1'b1, wr: 1'b0,
             addr: a, data: 16'h0000};
  endfunction

endpackage

// File: rtl/mult_bus_sequencer_arb.sv
// Two-way round-robin arbiter: on contention the
// requester not served last wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = req;
    endcase
  end

endmodule

// File: rtl/mult_bus_sequencer.sv
// Sequences multiply jobs from two requesters onto a bus-mapped
// multiplier. Optional done-poll timeout: MULT_SEQ_TIMEOUT_EN.
module mult_bus_sequencer
  import mult_bus_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int POLL_GAP       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [15:0] op_a0,
  input  logic [15:0] op_b0,
  input  logic [15:0] op_a1,
  input  logic [15:0] op_b1,
  output logic [1:0]  gnt,
  output logic [1:0]  res_valid,
  output logic [31:0] res,
  output logic [1:0]  err,
  output logic        cs,
  output logic        rd,
  output logic        wr,
  output logic [4:0]  addr,
  output logic [15:0] d_out,
  input  logic [31:0] d_in
);

  // POLL_CHK is the first idle cycle of the gap
  localparam logic [7:0] WAIT_LAST =
    8'((POLL_GAP >= 2) ? (POLL_GAP - 2) : 0);

  state_t      state;
  state_t      state_nxt;
  logic        last;
  logic [1:0]  sel;
  logic [1:0]  grant;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [31:0] res_q;
  logic [7:0]  wait_cnt;
  logic        timed_out;
  bus_t        bus;

  rr_arbiter2 u_arb (
    .req   (req),
    .last  (last),
    .grant (grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      last     <= 1'b1;
      sel      <= 2'b00;
      gnt      <= 2'b00;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= 2'b00;
      if (state == S_ARB && |grant) begin
        sel  <= grant;
        gnt  <= grant;
        last <= grant[1];
        a_q  <= grant[1] ? op_a1 : op_a0;
        b_q  <= grant[1] ? op_b1 : op_b0;
      end
      if (state == S_POLL_CHK)
        wait_cnt <= '0;
      else if (state == S_POLL_WAIT)
        wait_cnt <= wait_cnt + 8'd1;
      if (state == S_RES_CAP)
        res_q <= d_in;
    end
  end

`ifdef MULT_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] poll_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      poll_cnt <= '0;
    else if (state == S_ARB)
      poll_cnt <= '0;
    else if (state == S_POLL_RD)
      poll_cnt <= poll_cnt + 1'b1;
  end

  assign timed_out =
    (poll_cnt == TW'(TIMEOUT_CYCLES));
  assign err = (state == S_ABORT) ? sel : 2'b00;
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timed_out      = 1'b0;
  assign err            = 2'b00;
`endif

  always_comb begin
    state_nxt = state;
    bus       = '0;
    res_valid = 2'b00;
    unique case (state)
      S_IDLE:
        if (|req) state_nxt = S_ARB;
      S_ARB:
        state_nxt = (|grant) ? S_WR_A : S_IDLE;
      S_WR_A: begin
        bus       = bus_wr(ADDR_A, a_q);
        state_nxt = S_WR_B;
      end
      S_WR_B: begin
        bus       = bus_wr(ADDR_B, b_q);
        state_nxt = S_INIT_SET;
      end
      S_INIT_SET: begin
        bus       = bus_wr(ADDR_INIT, 16'h0001);
        state_nxt = S_INIT_CLR;
      end
      S_INIT_CLR: begin
        bus       = bus_wr(ADDR_INIT, 16'h0000);
        state_nxt = S_POLL_RD;
      end
      S_POLL_RD: begin
        bus       = bus_rd(ADDR_DONE);
        state_nxt = S_POLL_CHK;
      end
      S_POLL_CHK: begin
        if (d_in[0])
          state_nxt = S_RES_RD;
        else if (timed_out)
          state_nxt = S_ABORT;
        else if (POLL_GAP > 1)
          state_nxt = S_POLL_WAIT;
        else
          state_nxt = S_POLL_RD;
      end
      S_POLL_WAIT:
        if (wait_cnt == WAIT_LAST)
          state_nxt = S_POLL_RD;
      S_RES_RD: begin
        bus       = bus_rd(ADDR_RESULT);
        state_nxt = S_RES_CAP;
      end
      S_RES_CAP:
        state_nxt = S_RESP;
      S_RESP: begin
        res_valid = sel;
        state_nxt = S_IDLE;
      end
      S_ABORT: begin
        bus       = bus_wr(ADDR_INIT, 16'h0000);
        state_nxt = S_IDLE;
      end
      default:
        state_nxt = S_IDLE;
    endcase
  end

  assign {cs, rd, wr, addr, d_out} = bus;
  assign res = res_q;

endmodule
